// File: rtl/apb_slave.sv
// APB slave front-end: converts an APB access into a one-cycle read/write strobe
// toward a register block, then completes the access from the block's ack/error response.
module apb_slave #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              wack,
    input  logic              rack,
    input  logic              waddrerr,
    input  logic              raddrerr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                rsp_taken;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wdata_d    = wdata_q;
        prdata_d   = prdata_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rsp_taken  = 1'b0;

        case (state_q)
            IDLE: begin
                // Requiring penable=0 keeps a still-asserted access phase from restarting a transfer.
                if (psel && !penable) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    is_write_d = pwrite;
                    cnt_d      = '0;
                    state_d    = WAIT_RSP;
                    if (pwrite) begin
                        wr_en   = 1'b1;
                        waddr_d = paddr;
                        wdata_d = pwdata;
                    end else begin
                        rd_en   = 1'b1;
                        raddr_d = paddr;
                    end
                end
            end
            WAIT_RSP: begin
                if (is_write_q) begin
                    if (waddrerr) begin
                        rsp_taken = 1'b1;
                        err_d     = 1'b1;
                    end else if (wack) begin
                        rsp_taken = 1'b1;
                        err_d     = 1'b0;
                    end
                end else begin
                    if (raddrerr) begin
                        rsp_taken = 1'b1;
                        err_d     = 1'b1;
                        prdata_d  = '0;
                    end else if (rack) begin
                        rsp_taken = 1'b1;
                        err_d     = 1'b0;
                        prdata_d  = rdata;
                    end
                end

                if (rsp_taken) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
        end
    end

    // Address/data bypass the latch during the strobe cycle so the register block sees them with the strobe.
    assign waddr   = wr_en ? paddr  : waddr_q;
    assign wdata   = wr_en ? pwdata : wdata_q;
    assign raddr   = rd_en ? paddr  : raddr_q;
    assign prdata  = prdata_q;
    assign pready  = (state_q == DONE);
    assign pslverr = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_apb_slave.sv
// Randomized bench for apb_slave: acts as APB master and as a register block with a
// 16-word map, predicting completion, error and read data from the block's rules.
module tb_apb_slave;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, wr_en, rd_en;
    logic [31:0] waddr, raddr, wdata;
    logic [31:0] rdata = '0;
    logic        wack = 1'b0, rack = 1'b0, waddrerr = 1'b0, raddrerr = 1'b0;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [31:0] mem [16];
    logic [31:0] exp_prdata = '0;

    apb_slave #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .wr_en(wr_en), .rd_en(rd_en),
        .waddr(waddr), .raddr(raddr), .wdata(wdata),
        .rdata(rdata), .wack(wack), .rack(rack),
        .waddrerr(waddrerr), .raddrerr(raddrerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) wr_cnt++;
        if (rd_en) rd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h40);
    endfunction

    task automatic clear_rsp();
        wack = 1'b0; rack = 1'b0; waddrerr = 1'b0; raddrerr = 1'b0;
    endtask

    // One APB transfer; lat = cycles after the strobe at which the block responds.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int lat, input bit noresp);
        bit          valid;
        bit          exp_err;
        bit          got;
        int          cycles;
        int          wr_base;
        int          rd_base;
        logic [31:0] idx;
        valid   = addr_ok(addr);
        exp_err = noresp ? 1'b1 : !valid;
        idx     = {28'd0, addr[5:2]};
        got     = 1'b0;
        cycles  = 0;

        @(negedge clk);
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1;
        chk("wr_en_strobe", {31'd0, wr_en}, {31'd0, wr});
        chk("rd_en_strobe", {31'd0, rd_en}, {31'd0, !wr});
        if (wr) begin
            chk("waddr", waddr, addr);
            chk("wdata", wdata, data);
        end else begin
            chk("raddr", raddr, addr);
        end

        for (int i = 1; i <= TO + 4 && !got; i++) begin
            @(negedge clk);
            clear_rsp();
            if (!noresp && i == lat) begin
                if (wr) begin
                    waddrerr = !valid;
                    wack     = valid ? 1'b1 : 1'($urandom_range(0, 1));
                end else begin
                    raddrerr = !valid;
                    rack     = valid ? 1'b1 : 1'($urandom_range(0, 1));
                    rdata    = valid ? mem[idx[3:0]] : $urandom;
                end
            end else if (noresp || i < lat) begin
                // wrong-type responses must be ignored
                if (wr) begin
                    rack = 1'($urandom_range(0, 1)); raddrerr = 1'($urandom_range(0, 1));
                    rdata = $urandom;
                end else begin
                    wack = 1'($urandom_range(0, 1)); waddrerr = 1'($urandom_range(0, 1));
                end
            end
            #1;
            if (pready) begin
                got    = 1'b1;
                cycles = i;
            end
        end

        if (!got) begin
            chk("pready_seen", 32'd0, 32'd1);
        end else begin
            if (noresp)
                chk("timeout_lat", {31'd0, (cycles >= TO && cycles <= TO + 2)}, 32'd1);
            else
                chk("rsp_lat", cycles, lat + 1);
            chk("pslverr", {31'd0, pslverr}, {31'd0, exp_err});
            if (!wr && !noresp)
                exp_prdata = exp_err ? 32'd0 : mem[idx[3:0]];
            if (wr && !exp_err)
                mem[idx[3:0]] = data;
            chk("prdata", prdata, exp_prdata);
        end
        clear_rsp();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        #1;
        chk("pready_pulse", {31'd0, pready}, 32'd0);
        chk("pslverr_low", {31'd0, pslverr}, 32'd0);
        chk("wr_strobes", wr_cnt - wr_base, wr ? 1 : 0);
        chk("rd_strobes", rd_cnt - rd_base, wr ? 0 : 1);
        $display("xfer wr=%0d addr=%h data=%h lat=%0d noresp=%0d err=%0d prdata=%h",
                 wr, addr, data, lat, noresp, pslverr_dummy(exp_err), prdata);
    endtask

    function automatic int pslverr_dummy(input bit e);
        return int'(e);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_prdata"}, prdata, 32'd0);
        chk({tag, "_pready"}, {31'd0, pready}, 32'd0);
        chk({tag, "_pslverr"}, {31'd0, pslverr}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, wr_en, rd_en}, 32'd0);
        chk({tag, "_waddr"}, waddr, 32'd0);
        chk({tag, "_raddr"}, raddr, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        xfer(1'b1, 32'h0,  32'hA5,       1, 1'b0);
        xfer(1'b1, 32'h8,  32'h1FF,      2, 1'b0);
        xfer(1'b1, 32'hC,  32'h1,        3, 1'b0);
        xfer(1'b1, 32'h4,  32'hDEADBEEF, 1, 1'b0);
        xfer(1'b0, 32'h4,  32'h0,        1, 1'b0);
        xfer(1'b1, 32'hFF, 32'h1234,     1, 1'b0);
        xfer(1'b0, 32'h8,  32'h0,        2, 1'b0);
        xfer(1'b0, 32'hFF, 32'h0,        2, 1'b0);
        xfer(1'b1, 32'h10, 32'h55,       1, 1'b1);

        // reset while waiting for the response aborts the transfer
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        wack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_no_pready", {31'd0, pready}, 32'd0);
        end
        clear_rsp();
        psel = 1'b0; penable = 1'b0;
        exp_prdata = '0;
        @(negedge clk);
        rst = 1'b1;
        xfer(1'b0, 32'h8, 32'h0, 2, 1'b0);
        xfer(1'b1, 32'h14, 32'hCAFE, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            bit          w;
            a = 32'($urandom_range(0, 20)) * 4;
            if ($urandom_range(0, 7) == 0) a = a | 32'h1;
            w = 1'($urandom_range(0, 1));
            xfer(w, a, $urandom, $urandom_range(1, TO - 2),
                 w && ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
